// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: CPU request/ack and bridge bus bundle for the memory-access sequencer.
interface mem_access_seq_if;
  logic Req;
  logic Req_WE;
  logic [15:0] Req_ADDR;
  logic [15:0] Req_Data;
  logic Busy;
  logic Ack;
  logic [15:0] Rd_Data;
  logic [15:0] ADDR;
  logic OE;
  logic WE;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  modport master (
    output Req, Req_WE, Req_ADDR, Req_Data, Data_to_CPU,
    input  Busy, Ack, Rd_Data, ADDR, OE, WE, Data_from_CPU
  );
  modport slave (
    input  Req, Req_WE, Req_ADDR, Req_Data, Data_to_CPU,
    output Busy, Ack, Rd_Data, ADDR, OE, WE, Data_from_CPU
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences one CPU read/write into an address-setup cycle plus WAIT_STATES+1 access cycles.
module mem_access_seq #(
  parameter int WAIT_STATES = 2
) (
  input logic Clk,
  input logic Reset,
  mem_access_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic dir, dir_nxt, accept;
  logic [3:0] cnt;
  // DONE's exit edge samples Req like IDLE, so back-to-back requests repeat every WAIT_STATES+3 cycles
  assign accept = bus.Req && (state == IDLE || state == DONE);
  always_comb begin
    state_nxt = state;
    dir_nxt = accept ? bus.Req_WE : dir;
    case (state)
      IDLE:    state_nxt = accept ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (cnt == 4'd0) ? DONE : ACCESS;
      DONE:    state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      dir <= 1'b0;
    end else begin
      state <= state_nxt;
      dir <= dir_nxt;
    end
  end
  // Strobes are registered from the next state so the bridge sees no input-to-output path
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= 4'd0;
      bus.ADDR <= 16'd0;
      bus.Data_from_CPU <= 16'd0;
      bus.Rd_Data <= 16'd0;
      bus.Busy <= 1'b0;
      bus.Ack <= 1'b0;
      bus.OE <= 1'b0;
      bus.WE <= 1'b0;
    end else begin
      cnt <= accept ? 4'(WAIT_STATES) : (state == ACCESS && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        bus.ADDR <= bus.Req_ADDR;
        bus.Data_from_CPU <= bus.Req_Data;
      end
      if (state == ACCESS && cnt == 4'd0 && !dir)
        bus.Rd_Data <= bus.Data_to_CPU;
      bus.Busy <= state_nxt != IDLE;
      bus.Ack <= state_nxt == DONE;
      bus.OE <= !dir_nxt && (state_nxt == SETUP || state_nxt == ACCESS);
      bus.WE <= dir_nxt && state_nxt == ACCESS;
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: checks WAIT_STATES=0 and WAIT_STATES=2 sequencers against a timing/transaction model.
module tb_mem_access_seq;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_seq_if b0 ();
  mem_access_seq_if b2 ();
  mem_access_seq #(.WAIT_STATES(0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0));
  mem_access_seq #(.WAIT_STATES(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(b2));

  logic req = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = 16'd0, req_data = 16'd0, rdata = 16'd0;
  bit rnd = 1'b0;

  function automatic logic [15:0] bridge(logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  assign b0.Req = req;
  assign b0.Req_WE = req_we;
  assign b0.Req_ADDR = req_addr;
  assign b0.Req_Data = req_data;
  assign b0.Data_to_CPU = rnd ? bridge(b0.ADDR) : rdata;
  assign b2.Req = req;
  assign b2.Req_WE = req_we;
  assign b2.Req_ADDR = req_addr;
  assign b2.Req_Data = req_data;
  assign b2.Data_to_CPU = rnd ? bridge(b2.ADDR) : rdata;

  typedef struct packed {
    logic busy, ack, oe, we;
    logic [15:0] addr, dfc, rd;
  } obs_t;
  typedef struct packed {
    logic we;
    logic [15:0] addr, data;
  } txn_t;

  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_rd [2];

  function automatic obs_t obs(int s);
    return (s == 0) ? {b0.Busy, b0.Ack, b0.OE, b0.WE, b0.ADDR, b0.Data_from_CPU, b0.Rd_Data}
                    : {b2.Busy, b2.Ack, b2.OE, b2.WE, b2.ADDR, b2.Data_from_CPU, b2.Rd_Data};
  endfunction

  // Single transaction on the WAIT_STATES=2 unit; expected waveform derived from cycle number k
  task automatic run_txn(string nm, logic w, logic [15:0] a, logic [15:0] d, logic [15:0] r);
    obs_t o, e;
    int ws = 2;
    @(negedge Clk);
    req = 1'b1; req_we = w; req_addr = a; req_data = d; rdata = r;
    @(negedge Clk);
    req = 1'b0; req_addr = ~a; req_data = ~d; req_we = ~w;
    for (int k = 1; k <= ws + 4; k++) begin
      o = obs(1);
      e.busy = k <= ws + 3;
      e.ack = k == ws + 3;
      e.oe = !w && k <= ws + 2;
      e.we = w && k >= 2 && k <= ws + 2;
      e.addr = a;
      e.dfc = d;
      e.rd = (!w && k >= ws + 3) ? r : exp_rd[1];
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", nm, k, o, e);
      end
      @(negedge Clk);
    end
    if (!w) begin
      exp_rd[0] = r;
      exp_rd[1] = r;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #1 Reset = 1'b0;
    #10;
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      n_chk++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h want 0", s, o);
      end
    end
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    req = 1'b1; req_we = 1'b1; req_addr = 16'hA5A5; req_data = 16'h3C3C;
    @(negedge Clk) req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_chk++;
    if (b2.WE !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_we: got %b want 1", b2.WE);
    end
    #2 Reset = 1'b0;
    #1 o = obs(1);
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_async_abort: got %h want 0", o);
    end
    repeat (2) begin
      @(negedge Clk);
      n_chk++;
      if (b2.Ack !== 1'b0 || b2.Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_ack: got ack %b busy %b want 0 0", b2.Ack, b2.Busy);
      end
    end
    Reset = 1'b1;
    exp_rd[0] = 16'd0;
    exp_rd[1] = 16'd0;
    run_txn("reset_recover", 1'b0, 16'h1357, 16'h0000, 16'h2468);
  endtask

  task automatic test_read();
    run_txn("read_3000", 1'b0, 16'h3000, 16'h0F0F, 16'hBEEF);
  endtask

  task automatic test_write_io();
    run_txn("write_ffff", 1'b1, 16'hFFFF, 16'h1234, 16'h0000);
  endtask

  task automatic test_ignore_busy();
    obs_t o, e;
    @(negedge Clk);
    req = 1'b1; req_we = 1'b1; req_addr = 16'h3000; req_data = 16'h1111;
    @(negedge Clk);
    for (int k = 1; k <= 11; k++) begin
      o = obs(1);
      e.busy = k <= 10;
      e.ack = k == 5 || k == 10;
      e.oe = 1'b0;
      e.we = (k >= 2 && k <= 4) || (k >= 7 && k <= 9);
      e.addr = (k <= 5) ? 16'h3000 : 16'h4000;
      e.dfc = (k <= 5) ? 16'h1111 : 16'h2222;
      e.rd = exp_rd[1];
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ignore_busy cycle %0d: got %h want %h", k, o, e);
      end
      if (k == 2) begin
        req_addr = 16'h4000;
        req_data = 16'h2222;
      end
      if (k == 6) req = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic test_zero_wait();
    obs_t o, e;
    @(negedge Clk);
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_data = 16'h0000; rdata = 16'h00A5;
    @(negedge Clk);
    for (int k = 1; k <= 7; k++) begin
      o = obs(0);
      e.busy = k <= 6;
      e.ack = k == 3 || k == 6;
      e.oe = k <= 2;
      e.we = k == 5;
      e.addr = (k <= 3) ? 16'h0010 : 16'h0020;
      e.dfc = (k <= 3) ? 16'h0000 : 16'h5555;
      e.rd = (k >= 3) ? 16'h00A5 : exp_rd[0];
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_wait cycle %0d: got %h want %h", k, o, e);
      end
      if (k == 1) begin
        req_we = 1'b1;
        req_addr = 16'h0020;
        req_data = 16'h5555;
      end
      if (k == 4) req = 1'b0;
      @(negedge Clk);
    end
    exp_rd[0] = 16'h00A5;
  endtask

  // Transaction-level scoreboard: each accepted request must come back as exactly one Ack, in order
  task automatic test_random();
    obs_t os [2];
    obs_t e;
    txn_t t;
    txn_t q0 [$];
    txn_t q1 [$];
    int acc [2] = '{0, 0};
    int acks [2] = '{0, 0};
    bit prev_ack [2] = '{1'b0, 1'b0};
    int cyc = 0;
    bit done = 1'b0;
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    exp_rd[0] = 16'd0;
    exp_rd[1] = 16'd0;
    rnd = 1'b1;
    while (!done && cyc < 20000) begin
      @(negedge Clk);
      cyc++;
      for (int s = 0; s < 2; s++) begin
        os[s] = obs(s);
        n_chk++;
        if (os[s].oe && os[s].we) begin
          n_fail++;
          $display("FAIL oe_we_overlap dut%0d cycle %0d: got both 1 want exclusive", s, cyc);
        end
        n_chk++;
        if (!os[s].busy && (os[s].oe || os[s].we || os[s].ack)) begin
          n_fail++;
          $display("FAIL idle_strobe dut%0d cycle %0d: got %h want no strobes", s, cyc, os[s]);
        end
        n_chk++;
        if (os[s].ack && prev_ack[s]) begin
          n_fail++;
          $display("FAIL ack_twice dut%0d cycle %0d: got 2-cycle ack want 1", s, cyc);
        end
        prev_ack[s] = os[s].ack;
        if (os[s].ack) begin
          acks[s]++;
          n_chk++;
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            n_fail++;
            $display("FAIL spurious_ack dut%0d cycle %0d: got ack want none", s, cyc);
          end else begin
            if (s == 0) t = q0.pop_front();
            else t = q1.pop_front();
            if (!t.we) exp_rd[s] = bridge(t.addr);
            e = {1'b1, 1'b1, 1'b0, 1'b0, t.addr, t.data, exp_rd[s]};
            if (os[s] !== e) begin
              n_fail++;
              $display("FAIL random_done dut%0d cycle %0d: got %h want %h", s, cyc, os[s], e);
            end
          end
        end
      end
      if (acc[1] >= 1000) begin
        req = 1'b0;
        done = !os[0].busy && !os[1].busy;
      end else begin
        req = $urandom_range(0, 3) != 0;
        req_we = 1'($urandom_range(0, 1));
        req_addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        req_data = 16'($urandom);
      end
      t = {req_we, req_addr, req_data};
      for (int s = 0; s < 2; s++)
        if (req && (!os[s].busy || os[s].ack)) begin
          acc[s]++;
          if (s == 0) q0.push_back(t);
          else q1.push_back(t);
        end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d requests after %0d cycles want 1000 drained", acc[1], cyc);
    end
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (acks[s] !== acc[s]) begin
        n_fail++;
        $display("FAIL ack_count dut%0d: got %0d acks want %0d", s, acks[s], acc[s]);
      end
    end
    rnd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_io();
    test_ignore_busy();
    test_zero_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
